univ_shift_reg: RTL

- Parametrised successor to the team's latch and master-slave flip-flop storage cells: a WIDTH-bit edge-triggered register with eight operating modes.
- Modes: hold, parallel load, logical/arithmetic shifts, rotates, clear.
- Adds a multi-cycle "shift by N" sequencer: one bit per clock, with Busy/Done handshake.
- Used as the datapath register for later shifter/serialiser labs on the DE2 board.

---
 rtl/univ_shift_reg.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/univ_shift_reg.sv
// Parametrised universal shift register: eight modes plus a multi-cycle "shift by N"
// sequencer with busy/done handshake. Define UNIV_SHIFT_CARRY_EN to add a carry output.
module univ_shift_reg #(
  parameter int WIDTH = 8,
  parameter int AMT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] d,
  input  logic             ser_in_l,
  input  logic             ser_in_r,
  input  logic             start,
  input  logic [AMT_W-1:0] amount,
  output logic [WIDTH-1:0] q,
  output logic             ser_out_l,
  output logic             ser_out_r,
  output logic             busy,
  output logic             done
`ifdef UNIV_SHIFT_CARRY_EN
  ,
  output logic             carry
`endif
);

  typedef enum logic [2:0] {
    OP_HOLD = 3'b000,
    OP_LOAD = 3'b001,
    OP_SHL  = 3'b010,
    OP_SHR  = 3'b011,
    OP_ASR  = 3'b100,
    OP_ROL  = 3'b101,
    OP_ROR  = 3'b110,
    OP_CLR  = 3'b111
  } op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state, state_n;
  op_t              op, op_n;
  op_t              step_op;
  logic             step_en;
  logic [AMT_W-1:0] cnt, cnt_n;
  logic [WIDTH-1:0] q_n;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      op    <= OP_HOLD;
      cnt   <= '0;
      q     <= '0;
    end else begin
      state <= state_n;
      op    <= op_n;
      cnt   <= cnt_n;
      q     <= q_n;
    end
  end

  // A running sequence owns the register; otherwise Start wins over a single En step.
  always_comb begin
    state_n = state;
    op_n    = op;
    cnt_n   = cnt;
    step_en = 1'b0;
    step_op = op_t'(mode);
    case (state)
      RUN: begin
        step_en = 1'b1;
        step_op = op;
        cnt_n   = cnt - AMT_W'(1);
        if (cnt <= AMT_W'(1))
          state_n = DONE;
      end
      default: begin
        state_n = IDLE;
        if (start) begin
          op_n  = op_t'(mode);
          cnt_n = amount;
          if (amount == '0 || mode < 3'b010 || mode > 3'b110)
            state_n = DONE;
          else
            state_n = RUN;
        end else if (en) begin
          step_en = 1'b1;
        end
      end
    endcase
  end

  always_comb begin
    q_n = q;
    if (step_en) begin
      case (step_op)
        OP_LOAD: q_n = d;
        OP_SHL:  q_n = {q[WIDTH-2:0], ser_in_r};
        OP_SHR:  q_n = {ser_in_l, q[WIDTH-1:1]};
        OP_ASR:  q_n = {q[WIDTH-1], q[WIDTH-1:1]};
        OP_ROL:  q_n = {q[WIDTH-2:0], q[WIDTH-1]};
        OP_ROR:  q_n = {q[0], q[WIDTH-1:1]};
        OP_CLR:  q_n = '0;
        default: q_n = q;
      endcase
    end
  end

`ifdef UNIV_SHIFT_CARRY_EN
  logic carry_n;

  // Carry catches the bit that falls off the end of each shift or rotate step.
  always_comb begin
    carry_n = carry;
    if (step_en) begin
      case (step_op)
        OP_SHL, OP_ROL:         carry_n = q[WIDTH-1];
        OP_SHR, OP_ASR, OP_ROR: carry_n = q[0];
        OP_LOAD, OP_CLR:        carry_n = 1'b0;
        default:                carry_n = carry;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset)
      carry <= 1'b0;
    else
      carry <= carry_n;
  end
`endif

  assign ser_out_l = q[WIDTH-1];
  assign ser_out_r = q[0];
  assign busy      = (state == RUN);
  assign done      = (state == DONE);

endmodule
